// File: rtl/bcd_disp_pkg.sv
// bcd_disp_pkg: shared converter state type, seven-segment table and sizing helper for bcd_display_mux
package bcd_disp_pkg;

  typedef enum logic [1:0] {IDLE, CONV, DONE} conv_state_t;

  localparam logic [6:0] SEG_OFF = 7'h00;

  // Active-high ABCDEFG on bits 0..6; codes A-F are dark
  localparam logic [15:0][6:0] SEG_LUT = {
    {6{7'h00}},
    7'h6F, 7'h7F, 7'h07, 7'h7D, 7'h6D,
    7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F
  };

  function automatic longint pow10(input int n);
    longint p;
    p = 1;
    for (int i = 0; i < n; i++) p = p * 10;
    return p;
  endfunction

endpackage

// File: rtl/bcd_dabble_seq.sv
// bcd_dabble_seq: sequential shift-add-3 binary to BCD converter, one bit per cycle, start/busy/done handshake
module bcd_dabble_seq
  import bcd_disp_pkg::*;
#(
  parameter int BIN_W  = 8,
  parameter int DIGITS = 3
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  i_start,
  input  logic [BIN_W-1:0]      i_bin,
  output logic                  o_busy,
  output logic                  o_done,
  output logic [4*DIGITS-1:0]   o_bcd
);

  localparam int DW = 4 * DIGITS;
  localparam int CW = $clog2(BIN_W + 1);

  conv_state_t     r_st;
  logic [CW-1:0]   r_cnt;
  logic [BIN_W-1:0] r_bin;
  logic [DW-1:0]   r_bcd;
  logic            r_done;
  logic [DW-1:0]   w_adj;

  for (genvar d = 0; d < DIGITS; d++) begin : g_adj
    assign w_adj[4*d +: 4] = (r_bcd[4*d +: 4] >= 4'd5) ? r_bcd[4*d +: 4] + 4'd3 : r_bcd[4*d +: 4];
  end

  // Snapshot on start, then BIN_W adjust-and-shift steps; DONE lasts one cycle and never aborts early
  always_ff @(posedge clk)
    if (!rst_n) begin
      r_st   <= IDLE;
      r_cnt  <= '0;
      r_bin  <= '0;
      r_bcd  <= '0;
      r_done <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_st)
        IDLE:
          if (i_start) begin
            r_st  <= CONV;
            r_bin <= i_bin;
            r_bcd <= '0;
            r_cnt <= '0;
          end
        CONV: begin
          r_bcd <= {w_adj[DW-2:0], r_bin[BIN_W-1]};
          r_bin <= r_bin << 1;
          r_cnt <= r_cnt + 1'b1;
          if (r_cnt == CW'(BIN_W - 1)) begin
            r_st   <= DONE;
            r_done <= 1'b1;
          end
        end
        default: r_st <= IDLE;
      endcase
    end

  assign o_busy = r_st != IDLE;
  assign o_done = r_done;
  assign o_bcd  = r_bcd;

endmodule

// File: rtl/bcd_display_mux.sv
// bcd_display_mux: prescaled up/down/loadable counter, sequential BCD conversion and multiplexed seven-segment scan.
// Optional macro LZ_BLANK_EN: blank leading-zero digits above the units digit.
module bcd_display_mux
  import bcd_disp_pkg::*;
#(
  parameter int BIN_W          = 8,
  parameter int DIGITS         = 3,
  parameter int TICK_DIV       = 12500000,
  parameter int REFRESH_W      = 14,
  parameter bit SEG_ACTIVE_LOW = 1'b0,
  parameter bit DIG_ACTIVE_LOW = 1'b1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en_i,
  input  logic              up_i,
  input  logic              load_i,
  input  logic [BIN_W-1:0]  load_val_i,
  output logic [BIN_W-1:0]  count_o,
  output logic              bcd_valid_o,
  output logic [6:0]        seg_o,
  output logic              dp_o,
  output logic [DIGITS-1:0] dig_o
);

  localparam int PW = $clog2(TICK_DIV);
  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int DW = 4 * DIGITS;

`ifdef LZ_BLANK_EN
  localparam bit LZ = 1'b1;
`else
  localparam bit LZ = 1'b0;
`endif

  if (pow10(DIGITS) <= (longint'(1) << BIN_W) - 1) begin : g_bad_digits
    $error("bcd_display_mux: DIGITS too small for BIN_W");
  end
  if (TICK_DIV < 2) begin : g_bad_tick
    $error("bcd_display_mux: TICK_DIV must be at least 2");
  end

  logic [PW-1:0]        r_pre;
  logic [BIN_W-1:0]     r_count;
  logic                 r_pend;
  logic                 r_valid;
  logic [DW-1:0]        r_disp;
  logic [REFRESH_W-1:0] r_ref;
  logic [IW-1:0]        r_idx;
  logic [6:0]           r_seg;
  logic [DIGITS-1:0]    r_dig;
  logic                 w_tick;
  logic                 w_chg;
  logic                 w_start;
  logic                 w_busy;
  logic                 w_done;
  logic [DW-1:0]        w_bcd;
  logic [3:0]           w_nib;
  logic                 w_hide;
  logic [6:0]           w_seg;

  assign w_tick  = r_pre == PW'(TICK_DIV - 1);
  assign w_chg   = load_i | (w_tick & en_i);
  assign w_start = r_pend & ~w_busy;

  // Prescaler and counter; a load restarts the tick period, so a coincident tick is dropped
  always_ff @(posedge clk)
    if (!rst_n) begin
      r_pre   <= '0;
      r_count <= '0;
    end else if (load_i) begin
      r_pre   <= '0;
      r_count <= load_val_i;
    end else begin
      r_pre <= w_tick ? '0 : r_pre + 1'b1;
      if (w_tick & en_i) r_count <= up_i ? r_count + 1'b1 : r_count - 1'b1;
    end

  bcd_dabble_seq #(
    .BIN_W  (BIN_W),
    .DIGITS (DIGITS)
  ) u_conv (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_start (w_start),
    .i_bin   (r_count),
    .o_busy  (w_busy),
    .o_done  (w_done),
    .o_bcd   (w_bcd)
  );

  // Pending change tracking and display write; valid only when the written value is still current
  always_ff @(posedge clk)
    if (!rst_n) begin
      r_pend  <= 1'b0;
      r_valid <= 1'b1;
      r_disp  <= '0;
    end else begin
      r_pend  <= w_chg | (r_pend & ~w_start);
      r_valid <= w_chg ? 1'b0 : (w_done ? ~r_pend : r_valid);
      if (w_done) r_disp <= w_bcd;
    end

  // Refresh counter; each wrap moves the scan to the next digit
  always_ff @(posedge clk)
    if (!rst_n) begin
      r_ref <= '0;
      r_idx <= '0;
    end else begin
      r_ref <= r_ref + 1'b1;
      if (&r_ref) r_idx <= (r_idx == IW'(DIGITS - 1)) ? '0 : r_idx + 1'b1;
    end

  // Select the scanned nibble and encode it, blanking leading zeros when enabled
  always_comb begin
    w_nib  = 4'h0;
    w_hide = 1'b0;
    for (int k = 0; k < DIGITS; k++)
      if (r_idx == IW'(k)) begin
        w_nib  = r_disp[4*k +: 4];
        w_hide = LZ && (k != 0) && ((r_disp >> (4 * k)) == '0);
      end
    w_seg = w_hide ? SEG_OFF : SEG_LUT[w_nib];
  end

  // Segments and digit enables registered together so they switch on the same edge
  always_ff @(posedge clk)
    if (!rst_n) begin
      r_seg <= SEG_OFF ^ {7{SEG_ACTIVE_LOW}};
      r_dig <= {DIGITS{DIG_ACTIVE_LOW}};
    end else begin
      r_seg <= w_seg ^ {7{SEG_ACTIVE_LOW}};
      r_dig <= (DIGITS'(1) << r_idx) ^ {DIGITS{DIG_ACTIVE_LOW}};
    end

  assign count_o     = r_count;
  assign bcd_valid_o = r_valid;
  assign seg_o       = r_seg;
  assign dp_o        = SEG_ACTIVE_LOW;
  assign dig_o       = r_dig;

endmodule

// File: doc/bcd_display_mux.md
# bcd_display_mux

Parametrised multi-digit BCD counter and multiplexed seven-segment driver: a prescaled up/down/loadable binary counter is converted to BCD by a sequential shift-add-3 engine and scanned onto a common-segment display one digit at a time. It is the generalised successor of the fixed 8-bit, 3-digit, up-only counter-display top. It sits directly behind the chip top, driving the segment pins and digit-enable pins.

## Interface
- BIN_W, 8: binary counter width.
- DIGITS, 3: number of BCD digits and display digits. Must satisfy 10^DIGITS > 2^BIN_W - 1; elaboration error otherwise.
- TICK_DIV, 12500000: clk cycles per count tick. Must be ≥ 2.
- REFRESH_W, 14: clk cycles per digit scan slot = 2^REFRESH_W.
- SEG_ACTIVE_LOW, 0: 1 inverts seg_o and dp_o.
- DIG_ACTIVE_LOW, 1: 1 means a selected digit drives 0.

Ports:
- clk, in, 1: clock.
- rst_n, in, 1: reset, synchronous, active-low.
- en_i, in, 1: count enable, sampled on tick.
- up_i, in, 1: 1 = count up, 0 = count down.
- load_i, in, 1: synchronous load strobe.
- load_val_i, in, BIN_W: load value.
- count_o, out, BIN_W: current binary count.
- bcd_valid_o, out, 1: display register matches count_o.
- seg_o, out, 7: segments; bit0 = A … bit6 = G.
- dp_o, out, 1: decimal point, always off.
- dig_o, out, DIGITS: digit enables; bit0 = units.

## Operation
- Prescaler:
  - Counts 0..TICK_DIV-1 and wraps.
  - tick = 1 for one cycle when the prescaler equals TICK_DIV-1.
- Counter update priority:
  - load_i: count ← load_val_i and the prescaler clears to 0.
  - Otherwise tick & en_i: up wraps 2^BIN_W-1 → 0; down wraps 0 → 2^BIN_W-1.
  - Otherwise hold.
- Converter FSM:
  - IDLE: enters CONV when a count change is pending. It snapshots count_o and clears the BCD shift register.
  - CONV: runs BIN_W iterations, one per cycle. Each iteration adds 3 to every BCD nibble ≥ 5, then shifts left one bit, inserting the next binary MSB.
  - DONE: writes the DIGITS×4 result into the display register, then returns to IDLE.
  - A count change during CONV/DONE sets the pending flag. The conversion in progress completes and a new one starts from IDLE on the next cycle. The engine never aborts mid-conversion.
- bcd_valid_o:
  - Cleared the cycle after any count change.
  - Set on the DONE write only if no change is pending.
- Scanner:
  - REFRESH_W-bit refresh counter. On wrap, the digit index advances 0 → DIGITS-1 → 0.
  - The index selects a display-register nibble, which is encoded to seven segments. Non-BCD nibbles (A–F) encode as all segments off.
  - seg_o and dig_o are registered together, so segments and enables switch in the same cycle with no ghosting.

## Timing
- Reset values:
  - count_o = 0, prescaler = 0, refresh counter = 0, digit index = 0.
  - Display register = 0, FSM = IDLE, pending = 0, bcd_valid_o = 1.
  - seg_o and dp_o = off; dig_o = all inactive, with polarity applied.
- First valid scan output appears 1 cycle after reset release.
- Count change to display update: pending is set on change cycle n. The FSM leaves IDLE at n+1, CONV occupies n+1..n+BIN_W, and DONE writes at n+BIN_W+1. bcd_valid_o is high from n+BIN_W+2.
- Scan: each digit is active for exactly 2^REFRESH_W cycles. Digit-index to pin latency is 1 cycle.
- Reset asserted mid-conversion or mid-scan returns every register to its reset value on that edge.
- load_i coinciding with a tick: the load wins and that tick is discarded.

## Configuration
- LZ_BLANK_EN defined: a digit k > 0 is blanked (all segments off, enable still scanned) when it and every higher digit are zero. Digit 0 is always shown.
- LZ_BLANK_EN undefined: all digits display, including leading zeros.

## Structure
- Package bcd_disp_pkg holds:
  - the FSM state enum (IDLE, CONV, DONE);
  - the 16-entry segment lookup constant, active-high, ABCDEFG on bits 0..6;
  - the SEG_OFF constant.
- Sub-module bcd_dabble_seq contains the sequential converter: start/busy/done handshake, parameters BIN_W and DIGITS.
- The top module holds the prescaler, counter, pending flag, display register, scanner and output registers.

## Test plan
All scenarios use BIN_W=8, DIGITS=3, TICK_DIV=4, REFRESH_W=2 unless stated.
- Reset, then up count with en_i=1 for 4 ticks → count_o = 4, one tick every 4 cycles. The display register reads 0x004 at 10 cycles after the final change, and bcd_valid_o is high from then on.
- load 255, then one up tick → count_o = 0 (wrap). With up_i=0 from 0 → 255; display 2,5,5.
- load 199, then load 200 two cycles later (mid-CONV) → the first conversion completes and bcd_valid_o stays low. A second conversion follows, and the final display reads 2,0,0 with bcd_valid_o = 1.
- Scan check at count 123 → dig_o cycles 110, 101, 011 with 4 cycles per digit; seg_o = 3, 2, 1 patterns in step.
- LZ_BLANK_EN, count 7 → digits 1 and 2 show SEG_OFF, digit 0 shows 7. Without the macro, digits show 0,0,7.
- rst_n low during CONV → the next cycle shows all reset values, and no stale DONE write occurs afterwards.
